// File: rtl/sp_ram_clr.sv
// Single-port synchronous RAM. It provides per-lane write masking, a selectable
// read latency with a read-valid strobe, and a sequential clear engine. The
// clear engine fills the whole array with CLR_VALUE after reset or when
// requested with clr.
module sp_ram_clr #(
    parameter int unsigned           RAM_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           LANE_WIDTH = 8,
    parameter int unsigned           OUT_REG    = 0,
    parameter logic [RAM_WIDTH-1:0]  CLR_VALUE  = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr,
    output logic                                busy,
    input  logic                                wr_en,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               addr,
    input  logic [RAM_WIDTH-1:0]                din,
    input  logic [RAM_WIDTH/LANE_WIDTH-1:0]     wr_mask,
    output logic [RAM_WIDTH-1:0]                dout,
    output logic                                dout_vld
);

    localparam int unsigned            NUM_LANES = RAM_WIDTH / LANE_WIDTH;
    localparam int unsigned            DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [RAM_WIDTH-1:0]    mem [DEPTH];

    logic                    user_ok;
    logic                    wr_ok;
    logic                    rd_ok;

    // The user port owns the array only in IDLE and outside reset.
    assign user_ok = !rst && (state == IDLE);
    assign wr_ok   = user_ok && wr_en;
    assign rd_ok   = user_ok && rd_en;

    // busy is decoded directly from the state register.
    assign busy    = (state == CLEAR);

    // Clear-engine FSM: sweep clr_addr across the array, then release the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    if (clr_addr == LAST_ADDR) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // Array write port: the clear engine has priority, and user writes are lane-masked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= CLR_VALUE;
            end else if (wr_ok) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (wr_mask[i]) begin
                        mem[addr][i*LANE_WIDTH +: LANE_WIDTH] <= din[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_lat1
            // Single-stage read. The non-blocking read of mem makes a same-address write read-first.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout     <= '0;
                    dout_vld <= 1'b0;
                end else begin
                    dout_vld <= rd_ok;
                    if (rd_ok) begin
                        dout <= mem[addr];
                    end
                end
            end
        end else begin : g_lat2
            logic                  rd_vld_q;
            logic [RAM_WIDTH-1:0]  rd_data_q;

            // First read stage: valid bit, cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_vld_q <= 1'b0;
                end else begin
                    rd_vld_q <= rd_ok;
                end
            end

            // First read stage: the array word, captured only on an accepted read.
            always_ff @(posedge clk) begin
                if (rd_ok) begin
                    rd_data_q <= mem[addr];
                end
            end

            // Output register. In-flight reads finish even after a clear has begun.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout     <= '0;
                    dout_vld <= 1'b0;
                end else begin
                    dout_vld <= rd_vld_q;
                    if (rd_vld_q) begin
                        dout <= rd_data_q;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_clr.sv
// Directed bench for sp_ram_clr. One instance uses OUT_REG=0 and a second uses
// OUT_REG=1, and both receive the same stimulus. The second instance is
// checked one cycle behind the first.
module tb_sp_ram_clr;

    localparam logic [15:0] CV = 16'hA5A5;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [1:0]  wr_mask;

    logic        busy0;
    logic        busy1;
    logic [15:0] dout0;
    logic [15:0] dout1;
    logic        vld0;
    logic        vld1;

    int n_chk  = 0;
    int n_fail = 0;

    sp_ram_clr #(
        .RAM_WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .OUT_REG(0), .CLR_VALUE(CV)
    ) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy0), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .din(din), .wr_mask(wr_mask), .dout(dout0), .dout_vld(vld0)
    );

    sp_ram_clr #(
        .RAM_WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .OUT_REG(1), .CLR_VALUE(CV)
    ) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .din(din), .wr_mask(wr_mask), .dout(dout1), .dout_vld(vld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic        rd_en;
        logic [3:0]  addr;
        logic [15:0] din;
        logic [1:0]  mask;
        logic        exp_vld;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; din = '0; wr_mask = '0;
    endtask

    // Watchdog: a hang would be a design fault.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          nv0;
        int          nv1;
        logic        prev_vld;
        logic [15:0] prev_dout;

        // Stimulus table: reads after the reset clear, masked writes, read-first and the null mask.
        for (int a = 0; a < 16; a++) vecs.push_back('{1'b0, 1'b1, 4'(a), 16'h0000, 2'b00, 1'b1, CV});
        vecs.push_back('{1'b1, 1'b0, 4'd3, 16'h1234, 2'b11, 1'b0, CV});
        vecs.push_back('{1'b1, 1'b0, 4'd3, 16'hFFEE, 2'b01, 1'b0, CV});
        vecs.push_back('{1'b0, 1'b1, 4'd3, 16'h0000, 2'b00, 1'b1, 16'h12EE});
        vecs.push_back('{1'b1, 1'b0, 4'd5, 16'h0001, 2'b11, 1'b0, 16'h12EE});
        vecs.push_back('{1'b1, 1'b1, 4'd5, 16'h0002, 2'b11, 1'b1, 16'h0001});
        vecs.push_back('{1'b0, 1'b1, 4'd5, 16'h0000, 2'b00, 1'b1, 16'h0002});
        vecs.push_back('{1'b1, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b0, 16'h0002});
        vecs.push_back('{1'b0, 1'b1, 4'd3, 16'h0000, 2'b00, 1'b1, 16'h12EE});
        vecs.push_back('{1'b1, 1'b0, 4'd3, 16'h5600, 2'b10, 1'b0, 16'h12EE});
        vecs.push_back('{1'b0, 1'b1, 4'd3, 16'h0000, 2'b00, 1'b1, 16'h56EE});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 16'h56EE});

        // Reset held for 3 cycles.
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy0", busy0, 1);
        chk("reset_busy1", busy1, 1);
        chk("reset_vld0", vld0, 0);
        chk("reset_vld1", vld1, 0);
        chk("reset_dout0", dout0, 0);
        chk("reset_dout1", dout1, 0);

        // The clear after reset must last exactly 16 cycles.
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy0 && n < 40);
        chk("reset_clear_len", n, 16);
        chk("reset_clear_busy1", busy1, 0);

        // Table-driven traffic. dut1 shows the previous vector's result.
        prev_vld  = 1'b0;
        prev_dout = 16'h0000;
        foreach (vecs[i]) begin
            wr_en   = vecs[i].wr_en;
            rd_en   = vecs[i].rd_en;
            addr    = vecs[i].addr;
            din     = vecs[i].din;
            wr_mask = vecs[i].mask;
            tick();
            chk($sformatf("vec%0d_vld0", i), vld0, vecs[i].exp_vld);
            chk($sformatf("vec%0d_dout0", i), dout0, vecs[i].exp_dout);
            chk($sformatf("vec%0d_vld1", i), vld1, prev_vld);
            chk($sformatf("vec%0d_dout1", i), dout1, prev_dout);
            prev_vld  = vecs[i].exp_vld;
            prev_dout = vecs[i].exp_dout;
        end
        idle_inputs();
        tick();
        chk("tail_vld1", vld1, prev_vld);
        chk("tail_dout1", dout1, prev_dout);

        // Clear gating. The request in the clr cycle is accepted; later ones are dropped.
        clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 4'd7; din = 16'h1111; wr_mask = 2'b11;
        tick();
        chk("clr_start_busy", busy0, 1);
        chk("clr_start_vld0", vld0, 1);
        chk("clr_start_dout0", dout0, CV);
        clr = 1'b0;
        n = 0; nv0 = 0; nv1 = 0;
        do begin
            tick();
            n++;
            if (vld0) nv0++;
            if (n == 1) begin
                chk("clr_inflight_vld1", vld1, 1);
                chk("clr_inflight_dout1", dout1, CV);
            end else if (vld1) begin
                nv1++;
            end
            clr = (n == 5);
            if (!busy0) begin
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
        end while (busy0 && n < 40);
        chk("clr_len_with_reclr", n, 16);
        chk("clr_dropped_reads0", nv0, 0);
        chk("clr_dropped_reads1", nv1, 0);
        chk("clr_busy1_done", busy1, 0);
        idle_inputs();
        rd_en = 1'b1; addr = 4'd7;
        tick();
        chk("clr_addr7_vld0", vld0, 1);
        chk("clr_addr7_dout0", dout0, CV);

        // Reset in the middle of a clear restarts the full sweep.
        rd_en = 1'b0; wr_en = 1'b1; addr = 4'd12; din = 16'h0BAD; wr_mask = 2'b11;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        chk("pre_rst_addr12", dout0, 16'h0BAD);
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy_a", busy0, 1);
        tick();
        chk("midrst_busy_b", busy0, 1);
        chk("midrst_busy1", busy1, 1);
        chk("midrst_vld0", vld0, 0);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy0 && n < 40);
        chk("midrst_clear_len", n, 16);
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; addr = 4'(a);
            tick();
            chk($sformatf("midrst_rd%0d_vld0", a), vld0, 1);
            chk($sformatf("midrst_rd%0d_dout0", a), dout0, CV);
        end
        idle_inputs();
        tick();
        chk("final_vld1", vld1, 1);
        chk("final_dout1", dout1, CV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_ram_clr.md
Name: sp_ram_clr

Overview:
- Next-generation single-port synchronous RAM for the core's weight and neuron-state memories.
- Adds per-lane write masking, a selectable read pipeline depth with a read-valid strobe, and a built-in sequential clear engine.
- The clear engine fills every location with a constant after reset or on request, so parent blocks no longer sweep memory themselves.
- Sits directly under the neuron/synapse controllers, in place of plain RAM instances.

Parameters:
- RAM_WIDTH, 8: data word width in bits; must be an integer multiple of LANE_WIDTH.
- ADDR_WIDTH, 4: address bits; depth = 2**ADDR_WIDTH.
- LANE_WIDTH, 8: bits per write-mask lane; NUM_LANES = RAM_WIDTH/LANE_WIDTH (derived, localparam).
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- CLR_VALUE, 0: RAM_WIDTH-bit constant written to every location during a clear.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- clr, input, 1: single-cycle request to start a full-memory clear.
- busy, output, 1: high while the clear engine owns the array.
- wr_en, input, 1: write request.
- rd_en, input, 1: read request.
- addr, input, ADDR_WIDTH: shared read/write address.
- din, input, RAM_WIDTH: write data.
- wr_mask, input, NUM_LANES: per-lane write enable; bit i covers din[i*LANE_WIDTH +: LANE_WIDTH].
- dout, output, RAM_WIDTH: read data.
- dout_vld, output, 1: one-cycle strobe, high when dout carries the data of an accepted read.

Behaviour:
- Reset (rst=1 at a posedge):
  - state<=CLEAR, clr_addr<=0.
  - dout<=0, dout_vld<=0, all read pipeline valid bits <=0.
  - busy=1 while in reset.
  - Memory contents are not touched during the reset cycles themselves.
- FSM, two states, IDLE and CLEAR; busy = (state==CLEAR), decoded directly from the state register.
- CLEAR:
  - Each posedge with rst=0 writes CLR_VALUE to memory[clr_addr] (all lanes) and increments clr_addr.
  - At the posedge that writes address 2**ADDR_WIDTH-1, state<=IDLE and clr_addr wraps to 0.
  - A clear therefore occupies exactly 2**ADDR_WIDTH cycles after rst falls or after clr is sampled.
- IDLE: clr=1 at a posedge sets state<=CLEAR and clr_addr<=0. Clearing starts on the next cycle; the user request sampled in that same cycle is still accepted.
- clr while busy=1 is ignored; the clear in progress is not restarted.
- rst during CLEAR restarts the clear from address 0 once rst falls.
- User access is accepted only when busy=0 at the posedge.
  - wr_en/rd_en with busy=1 are dropped silently: no write, no dout_vld.
  - Requesters must hold off on busy.
- Write: wr_en=1 and busy=0 at the posedge updates memory[addr] lane i only where wr_mask[i]=1; other lanes keep their value.
- wr_mask=0 with wr_en=1 is legal and performs no write.
- Read, OUT_REG=0: rd_en=1 and busy=0 at edge N gives dout=memory[addr] and dout_vld=1 after edge N.
- Read, OUT_REG=1: the same request gives dout and dout_vld after edge N+1.
- dout holds its last value when no read completes; dout_vld is high for exactly one cycle per accepted read.
- Back-to-back reads are allowed every cycle; throughput is 1 read per cycle.
- Simultaneous rd_en and wr_en to the same address (the only possible case, since the port is shared) is read-first: dout returns the pre-write word.
- Reads accepted before a clear starts still complete through the pipeline with their pre-clear data, even if busy has risen.
- Memory contents are undefined until the first clear completes. The reset-triggered clear guarantees CLR_VALUE everywhere once busy first falls.

Test Plan:
- Reset and clear timing: RAM_WIDTH=16, ADDR_WIDTH=4, CLR_VALUE=16'hA5A5. Hold rst 3 cycles, release -> busy stays 1 for exactly 16 cycles then 0; read all 16 addresses -> each dout=16'hA5A5 with dout_vld one cycle after rd_en.
- Masked write: write 16'h1234 mask 2'b11 to addr 3, then 16'hFFEE mask 2'b01 to addr 3, then read addr 3 -> dout=16'h12EE.
- Read-during-write: memory[5]=16'h0001; in one cycle wr_en=1, rd_en=1, addr=5, din=16'h0002, mask=2'b11 -> dout=16'h0001; next read of addr 5 -> 16'h0002.
- Output register: OUT_REG=1, rd_en pulsed at cycles 10, 11, 12 on addrs 0, 1, 2 -> dout_vld high at cycles 12, 13, 14 with matching data; OUT_REG=0 gives cycles 11, 12, 13.
- Clear gating: clr pulsed, with wr_en=1 to addr 7 held through the busy period -> memory[7]=CLR_VALUE afterward; no dout_vld for rd_en issued while busy; a second clr mid-clear does not extend busy beyond 16 cycles.
- Reset mid-clear: assert rst at clear cycle 6 for 2 cycles -> busy stays 1, and after release busy lasts a full 16 cycles; all addresses read CLR_VALUE.
